// File: rtl/m8088_hold_arbiter.sv
// Bus-hold arbiter for the m8088: raises HOLD, waits for HOLDA, then grants the bus
// round-robin to one requester at a time with bounded tenure and a guaranteed CPU gap.
module m8088_hold_arbiter #(
  parameter int N_REQ        = 2,
  parameter int MAX_TENURE   = 64,
  parameter int CPU_GAP      = 4,
  parameter int BACK_TO_BACK = 1
) (
  input  logic             CORE_CLK,
  input  logic             RESET,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic             HOLD,
  input  logic             HOLDA,
  output logic             busy,
  output logic             revoked
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = $clog2(MAX_TENURE);
  localparam int GW = (CPU_GAP > 1) ? $clog2(CPU_GAP) : 1;
  localparam logic [PW-1:0] RR_INIT  = PW'(N_REQ - 1);
  localparam logic [TW-1:0] TEN_LAST = TW'(MAX_TENURE - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(CPU_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_GRANT   = 3'd2,
    S_HANDOFF = 3'd3,
    S_RELEASE = 3'd4,
    S_CPU_RUN = 3'd5
  } state_t;

  state_t           state_r, state_n;
  logic [N_REQ-1:0] gnt_r, gnt_n, gnt_win_s;
  logic             hold_r, hold_n, busy_r, revoked_r, revoked_n;
  logic [PW-1:0]    rr_r, rr_n, win_idx_s, cand_s;
  logic [TW-1:0]    tenure_r, tenure_n;
  logic [GW-1:0]    gap_r, gap_n;
  logic             win_found_s, any_req_s, owner_live_s, other_s, expire_s;

  // Round-robin pick: first requester strictly after the pointer, wrapping.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = rr_r;
    cand_s      = rr_r;
    gnt_win_s   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand_s = PW'((int'(rr_r) + i) % N_REQ);
      if (!win_found_s && req[cand_s]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
    gnt_win_s[win_idx_s] = 1'b1;
  end

  assign any_req_s    = |req;
  assign owner_live_s = |(req & gnt_r);
  assign other_s      = |(req & ~gnt_r);
  assign expire_s     = (tenure_r == TEN_LAST);

  // Next-state and next-output decode.
  always_comb begin
    state_n   = state_r;
    gnt_n     = gnt_r;
    hold_n    = hold_r;
    revoked_n = 1'b0;
    rr_n      = rr_r;
    tenure_n  = tenure_r;
    gap_n     = gap_r;
    case (state_r)
      S_IDLE: begin
        gnt_n  = '0;
        hold_n = 1'b0;
        if (any_req_s) begin
          state_n = S_REQ;
          hold_n  = 1'b1;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_REQ, S_HANDOFF: begin
        hold_n = 1'b1;
        if (HOLDA && win_found_s) begin
          state_n  = S_GRANT;
          gnt_n    = gnt_win_s;
          rr_n     = win_idx_s;
          tenure_n = '0;
        end else if (!any_req_s && (HOLDA || state_r == S_HANDOFF)) begin
          state_n = S_RELEASE;
          hold_n  = 1'b0;
        end else begin
          // HOLD is never withdrawn before the CPU has acknowledged it.
          state_n = S_REQ;
        end
      end
      S_GRANT: begin
        tenure_n = tenure_r + TW'(1);
        if (!HOLDA) begin
          gnt_n   = '0;
          hold_n  = 1'b0;
          state_n = S_RELEASE;
        end else if (!owner_live_s || expire_s) begin
          gnt_n     = '0;
          revoked_n = owner_live_s;
          if ((BACK_TO_BACK != 0) && other_s) begin
            state_n = S_HANDOFF;
          end else begin
            state_n = S_RELEASE;
            hold_n  = 1'b0;
          end
        end else begin
          state_n = S_GRANT;
        end
      end
      S_RELEASE: begin
        hold_n = 1'b0;
        gnt_n  = '0;
        if (!HOLDA) begin
          state_n = S_CPU_RUN;
          gap_n   = '0;
        end else begin
          state_n = S_RELEASE;
        end
      end
      S_CPU_RUN: begin
        hold_n = 1'b0;
        gnt_n  = '0;
        if (gap_r == GAP_LAST) begin
          state_n = S_IDLE;
        end else begin
          gap_n = gap_r + GW'(1);
        end
      end
      default: begin
        state_n = S_IDLE;
        gnt_n   = '0;
        hold_n  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CORE_CLK) begin
    if (RESET) begin
      state_r   <= S_IDLE;
      gnt_r     <= '0;
      hold_r    <= 1'b0;
      busy_r    <= 1'b0;
      revoked_r <= 1'b0;
      rr_r      <= RR_INIT;
      tenure_r  <= '0;
      gap_r     <= '0;
    end else begin
      state_r   <= state_n;
      gnt_r     <= gnt_n;
      hold_r    <= hold_n;
      busy_r    <= (state_n != S_IDLE);
      revoked_r <= revoked_n;
      rr_r      <= rr_n;
      tenure_r  <= tenure_n;
      gap_r     <= gap_n;
    end
  end

  assign gnt     = gnt_r;
  assign HOLD    = hold_r;
  assign busy    = busy_r;
  assign revoked = revoked_r;

endmodule
